iob_modcnt_sync: RTL
====================

IOB_MODCNT_SYNC -- requirements
Module: iob_modcnt_sync

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of count, modulus and error counter.
REQ-002 SHALL have parameter LOCK_N, default 4, consecutive consistent samples needed to lock (legal 2..255).
REQ-003 SHALL have parameter LOSS_N, default 2, consecutive mismatches while locked that drop lock (legal 1..255).
REQ-004 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-005 SHALL have port arst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-007 SHALL have port en  input  1  cnt_in valid this cycle.
REQ-008 SHALL have port cnt_in  input  DATA_W  received modulo-count sample from a transmitting modulo counter.
REQ-009 SHALL have port mod  input  DATA_W  modulus, held stable while operating.
REQ-010 SHALL have port expected  output  DATA_W  registered prediction of next sample.
REQ-011 SHALL have port locked  output  1  tracker locked to stream.
REQ-012 SHALL have port err  output  1  one-cycle pulse: mismatch while locked.
REQ-013 SHALL have port wrap  output  1  one-cycle pulse: matched sample equal to mod-1 while locked.
REQ-014 SHALL have port err_cnt  output  DATA_W  saturating mismatch count.

Function
REQ-015 SHALL define next(x) = 0 when x == mod-1 (DATA_W-bit wrap), else x+1; mod == 0 gives plain wrap at all-ones.
REQ-016 SHALL treat a sample as out-of-range when mod != 0 and cnt_in >= mod.
REQ-017 SHALL implement states UNLOCKED, LOCKING, LOCKED; locked = 1 only in LOCKED.
REQ-018 SHALL do nothing on cycles with en = 0; all state, expected and counters hold; err, wrap = 0.
REQ-019 UNLOCKED, en, in-range: expected <= next(cnt_in), match_cnt <= 1, go LOCKING; out-of-range: stay.
REQ-020 LOCKING, en, cnt_in == expected: match_cnt++, expected <= next(cnt_in); on reaching LOCK_N go LOCKED, miss_cnt <= 0.
REQ-021 LOCKING, en, mismatch in-range: restart, match_cnt <= 1, expected <= next(cnt_in); out-of-range: go UNLOCKED.
REQ-022 LOCKED, en, match: expected <= next(expected), miss_cnt <= 0, wrap = 1 if cnt_in == mod-1.
REQ-023 LOCKED, en, mismatch: err = 1, err_cnt++ saturating at all-ones, miss_cnt++, expected <= next(expected) (flywheel).
REQ-024 LOCKED mismatch making miss_cnt == LOSS_N SHALL go UNLOCKED, clear match_cnt and miss_cnt; err still pulses.
REQ-025 All outputs SHALL be registered; sample at edge N reflected on outputs after edge N, latency 1 cycle.
REQ-026 err, wrap, err_cnt SHALL never change outside LOCKED; err_cnt is cleared only by reset.

Reset
REQ-027 arst SHALL asynchronously force UNLOCKED, expected = 0, locked = 0, err = 0, wrap = 0, err_cnt = 0, match_cnt = miss_cnt = 0.
REQ-028 rst SHALL have identical effect synchronously and take priority over en in the same cycle, including mid-lock.

Structure
REQ-029 State encodings and next() width rule SHALL live in a shared package header used by iob_modcnt_sync and its bench.
REQ-030 SHALL be one module plus one natural sub-module, iob_modcnt_next, combinational next() with mod wrap.
REQ-031 match_cnt and miss_cnt SHALL be 8 bits.

Verification
REQ-032 mod=10, LOCK_N=4, samples 5,6,7,8 -> locked=1 the cycle after 8, expected=9.
REQ-033 Locked, mod=10, samples 8,9,0 -> wrap pulse after 9, expected=1 after 0, err never set.
REQ-034 Locked expecting 3, LOSS_N=2, samples 7,4 -> err after 7 (err_cnt=1), locked holds, 4 matches, miss_cnt clears; then samples 9,9 -> err_cnt=3, locked=0.
REQ-035 mod=10, UNLOCKED, sample 12 -> remains UNLOCKED; LOCKING with samples 2,3,12 -> UNLOCKED.
REQ-036 Locked stream, rst asserted with en=1 -> all outputs reset next cycle; arst mid-cycle -> immediate reset.
REQ-037 mod=0, samples FFFFFFFE, FFFFFFFF, 0, 1 -> locked after 1, expected=2, no err.

Source files
------------

// File: rtl/iob_modcnt_sync_pkg.sv
// iob_modcnt_sync_pkg: shared tracker state encoding and modulo next() rule
package iob_modcnt_sync_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    localparam int CNT_W = 8;
    localparam int MAX_W = 64;

    // Evaluated at w bits; mod == 0 makes mod-1 all-ones, i.e. a plain binary wrap
    function automatic logic [MAX_W-1:0] modcnt_next(input logic [MAX_W-1:0] x,
                                                     input logic [MAX_W-1:0] m,
                                                     input int unsigned w);
        logic [MAX_W-1:0] mask;
        mask = (w >= MAX_W) ? '1 : ((64'd1 << w) - 64'd1);
        return ((x & mask) == ((m - 64'd1) & mask)) ? '0 : ((x + 64'd1) & mask);
    endfunction

endpackage

// File: rtl/iob_modcnt_next.sv
// iob_modcnt_next: combinational successor of a modulo-mod counter value
module iob_modcnt_next
    import iob_modcnt_sync_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] mod,
    output logic [DATA_W-1:0] y
);

    assign y = DATA_W'(modcnt_next(64'(x), 64'(mod), DATA_W));

endmodule

// File: rtl/iob_modcnt_sync.sv
// iob_modcnt_sync: locks onto a received modulo-count stream and flags mismatches
module iob_modcnt_sync
    import iob_modcnt_sync_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LOCK_N = 4,
    parameter int LOSS_N = 2
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] cnt_in,
    input  logic [DATA_W-1:0] mod,
    output logic [DATA_W-1:0] expected,
    output logic              locked,
    output logic              err,
    output logic              wrap,
    output logic [DATA_W-1:0] err_cnt
);

    localparam logic [DATA_W-1:0] ONE    = DATA_W'(1);
    localparam logic [CNT_W-1:0]  LOCK_C = CNT_W'(LOCK_N);
    localparam logic [CNT_W-1:0]  LOSS_C = CNT_W'(LOSS_N);

    state_t            state;
    logic [CNT_W-1:0]  match_cnt;
    logic [CNT_W-1:0]  miss_cnt;
    logic [DATA_W-1:0] nxt_in;
    logic [DATA_W-1:0] nxt_exp;
    logic              oor;
    logic              hit;

    iob_modcnt_next #(.DATA_W(DATA_W)) u_next_in  (.x(cnt_in),   .mod(mod), .y(nxt_in));
    iob_modcnt_next #(.DATA_W(DATA_W)) u_next_exp (.x(expected), .mod(mod), .y(nxt_exp));

    assign oor = (mod != '0) && (cnt_in >= mod);
    assign hit = cnt_in == expected;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state     <= UNLOCKED;
            expected  <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
            wrap      <= 1'b0;
            err_cnt   <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
        end else if (rst) begin
            state     <= UNLOCKED;
            expected  <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
            wrap      <= 1'b0;
            err_cnt   <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
        end else begin
            err  <= 1'b0;
            wrap <= 1'b0;
            if (en) begin
                case (state)
                    UNLOCKED: begin
                        if (!oor) begin
                            expected  <= nxt_in;
                            match_cnt <= CNT_W'(1);
                            state     <= LOCKING;
                        end
                    end
                    LOCKING: begin
                        if (hit) begin
                            expected  <= nxt_in;
                            match_cnt <= match_cnt + CNT_W'(1);
                            if (match_cnt + CNT_W'(1) == LOCK_C) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                miss_cnt <= '0;
                            end
                        end else if (!oor) begin
                            expected  <= nxt_in;
                            match_cnt <= CNT_W'(1);
                        end else begin
                            state     <= UNLOCKED;
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        // Flywheel: prediction advances whether or not the sample matched
                        expected <= nxt_exp;
                        if (hit) begin
                            miss_cnt <= '0;
                            wrap     <= cnt_in == mod - ONE;
                        end else begin
                            err     <= 1'b1;
                            err_cnt <= (&err_cnt) ? err_cnt : err_cnt + ONE;
                            if (miss_cnt + CNT_W'(1) == LOSS_C) begin
                                state     <= UNLOCKED;
                                locked    <= 1'b0;
                                match_cnt <= '0;
                                miss_cnt  <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state  <= UNLOCKED;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
